// File: rtl/blake2_pkg.sv
// Shared BLAKE2 definitions: padder state encoding and per-variant block/word sizes.
// S_KPAD exists only when BLAKE2_PAD_KEY_EN is defined.
package blake2_pkg;

  localparam int unsigned BLAKE2B_BB = 128;
  localparam int unsigned BLAKE2B_W  = 64;
  localparam int unsigned BLAKE2S_BB = 64;
  localparam int unsigned BLAKE2S_W  = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DATA = 2'd1,
    S_PAD  = 2'd2
`ifdef BLAKE2_PAD_KEY_EN
    ,
    S_KPAD = 2'd3
`endif
  } pad_state_e;

endpackage

// File: rtl/blake2_msg_pad.sv
// Byte-stream message padder feeding the BLAKE2 compression core: cuts BB-byte blocks,
// zero-pads the final block and tracks the byte count ll. Optional BLAKE2_PAD_KEY_EN adds a keyed first block.
module blake2_msg_pad
  import blake2_pkg::*;
#(
  parameter int unsigned BB       = 128,
  parameter int unsigned LL_W     = 64,
  parameter int unsigned BB_CLOG2 = $clog2(BB)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [7:0]      in_data_i,
  input  logic            in_last_i,
  input  logic            in_empty_i,
`ifdef BLAKE2_PAD_KEY_EN
  input  logic [7:0]      key_len_i,
`endif
  input  logic            core_ready_i,
  output logic            data_v_o,
  output logic [7:0]      data_o,
  output logic            block_first_o,
  output logic            block_last_o,
  output logic [LL_W-1:0] ll_o,
  output logic            busy_o
);

  localparam logic [BB_CLOG2-1:0] BLK_LAST = BB_CLOG2'(BB - 1);
  localparam logic [LL_W-1:0]     LL_BLOCK = LL_W'(BB);

  pad_state_e            state_q, state_d;
  logic [BB_CLOG2-1:0]   cnt_q, cnt_d;
  logic                  first_q, first_d;
  logic                  last_q, last_d;
  logic [LL_W-1:0]       ll_q, ll_d;
  logic [7:0]            key_rem_q, key_rem_d;
  logic                  data_v_q, data_v_d;
  logic [7:0]            data_q, data_d;
  logic                  first_o_q, first_o_d;
  logic                  last_o_q, last_o_d;
  logic                  busy_q, busy_d;

  logic                  accept_s;
  logic                  start_s;
  logic [BB_CLOG2-1:0]   idx_s;
  logic                  cur_first_s;
  logic [LL_W-1:0]       ll_base_s;
  logic [7:0]            key_len_s;
  logic [7:0]            key_rem_s;
  logic                  in_key_s;
  logic                  blk_end_s;

`ifdef BLAKE2_PAD_KEY_EN
  assign key_len_s = key_len_i;
`else
  assign key_len_s = 8'd0;
`endif

  assign in_ready_o  = core_ready_i & ((state_q == S_IDLE) | (state_q == S_DATA));
  assign accept_s    = in_valid_i & in_ready_o;

  // A beat taken in IDLE opens a new message: index 0 of block 0, count restarts.
  assign start_s     = (state_q == S_IDLE);
  assign idx_s       = start_s ? {BB_CLOG2{1'b0}} : cnt_q;
  assign cur_first_s = start_s | first_q;
  assign ll_base_s   = start_s ? {LL_W{1'b0}} : ll_q;
  assign key_rem_s   = start_s ? key_len_s : key_rem_q;
  assign in_key_s    = (key_rem_s != 8'd0);
  assign blk_end_s   = (idx_s == BLK_LAST);

  // Next-state, counter and output-byte computation
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    first_d   = first_q;
    last_d    = last_q;
    ll_d      = ll_q;
    key_rem_d = key_rem_q;
    data_v_d  = 1'b0;
    data_d    = 8'h00;
    first_o_d = 1'b0;
    last_o_d  = 1'b0;
    case (state_q)
      S_IDLE, S_DATA: begin
        if (accept_s && !in_empty_i) begin
          data_v_d  = 1'b1;
          data_d    = in_data_i;
          first_o_d = cur_first_s;
          last_o_d  = in_last_i;
          cnt_d     = idx_s + BB_CLOG2'(1);
          first_d   = cur_first_s & ~blk_end_s;
          last_d    = in_last_i;
          ll_d      = ll_base_s + LL_W'(1);
          key_rem_d = in_key_s ? (key_rem_s - 8'd1) : 8'd0;
`ifdef BLAKE2_PAD_KEY_EN
          // Closing the key block: ll accounts for the whole padded block.
          if (in_key_s && ((key_rem_s == 8'd1) || in_last_i)) begin
            ll_d      = LL_BLOCK;
            key_rem_d = 8'd0;
            if (in_last_i) begin
              state_d = blk_end_s ? S_IDLE : S_PAD;
            end else begin
              state_d = blk_end_s ? S_DATA : S_KPAD;
            end
          end else if (in_last_i) begin
            state_d = blk_end_s ? S_IDLE : S_PAD;
          end else begin
            state_d = S_DATA;
          end
`else
          if (in_last_i) begin
            state_d = blk_end_s ? S_IDLE : S_PAD;
          end else begin
            state_d = S_DATA;
          end
`endif
        end else if (accept_s && in_last_i) begin
          // End marker with no byte: pad from the current index with last set.
          first_d   = cur_first_s;
          cnt_d     = idx_s;
          last_d    = 1'b1;
          key_rem_d = 8'd0;
          ll_d      = (in_key_s && !start_s) ? LL_BLOCK : ll_base_s;
          state_d   = S_PAD;
        end else begin
          state_d = state_q;
        end
      end
      S_PAD: begin
        if (core_ready_i) begin
          data_v_d  = 1'b1;
          first_o_d = first_q;
          last_o_d  = last_q;
          cnt_d     = cnt_q + BB_CLOG2'(1);
          state_d   = (cnt_q == BLK_LAST) ? S_IDLE : S_PAD;
        end else begin
          state_d = state_q;
        end
      end
`ifdef BLAKE2_PAD_KEY_EN
      S_KPAD: begin
        if (core_ready_i) begin
          data_v_d  = 1'b1;
          first_o_d = first_q;
          last_o_d  = 1'b0;
          cnt_d     = cnt_q + BB_CLOG2'(1);
          if (cnt_q == BLK_LAST) begin
            state_d = S_DATA;
            first_d = 1'b0;
          end else begin
            state_d = S_KPAD;
          end
        end else begin
          state_d = state_q;
        end
      end
`endif
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= {BB_CLOG2{1'b0}};
      first_q   <= 1'b0;
      last_q    <= 1'b0;
      ll_q      <= {LL_W{1'b0}};
      key_rem_q <= 8'd0;
      data_v_q  <= 1'b0;
      data_q    <= 8'h00;
      first_o_q <= 1'b0;
      last_o_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      first_q   <= first_d;
      last_q    <= last_d;
      ll_q      <= ll_d;
      key_rem_q <= key_rem_d;
      data_v_q  <= data_v_d;
      data_q    <= data_d;
      first_o_q <= first_o_d;
      last_o_q  <= last_o_d;
      busy_q    <= busy_d;
    end
  end

  assign data_v_o      = data_v_q;
  assign data_o        = data_q;
  assign block_first_o = first_o_q;
  assign block_last_o  = last_o_q;
  assign ll_o          = ll_q;
  assign busy_o        = busy_q;

endmodule

// File: tb/tb_blake2_msg_pad.sv
// Scoreboard bench for blake2_msg_pad: expected padded streams come from a block-level model;
// a negedge monitor pops and compares every byte the padder presents.
module tb_blake2_msg_pad;

  localparam int BB   = 128;
  localparam int LL_W = 64;

  logic            clk;
  logic            reset;
  logic            in_valid_i;
  logic            in_ready_o;
  logic [7:0]      in_data_i;
  logic            in_last_i;
  logic            in_empty_i;
  logic [7:0]      key_len_i;
  logic            core_ready_i;
  logic            data_v_o;
  logic [7:0]      data_o;
  logic            block_first_o;
  logic            block_last_o;
  logic [LL_W-1:0] ll_o;
  logic            busy_o;

  blake2_msg_pad #(.BB(BB), .LL_W(LL_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid_i   (in_valid_i),
    .in_ready_o   (in_ready_o),
    .in_data_i    (in_data_i),
    .in_last_i    (in_last_i),
    .in_empty_i   (in_empty_i),
`ifdef BLAKE2_PAD_KEY_EN
    .key_len_i    (key_len_i),
`endif
    .core_ready_i (core_ready_i),
    .data_v_o     (data_v_o),
    .data_o       (data_o),
    .block_first_o(block_first_o),
    .block_last_o (block_last_o),
    .ll_o         (ll_o),
    .busy_o       (busy_o)
  );

  typedef struct {
    logic [7:0]      d;
    logic            f;
    logic            l;
    logic [LL_W-1:0] ll;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  logic [7:0] msg[$];
  int         checks = 0;
  int         errors = 0;
  int         obs_cnt = 0;
  int         stall_at = -1;
  int         stall_start = 0;
  bit         stall_done = 1'b0;
  bit         cr_rand = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, want, $time);
    end
  endtask

  // Reference: message of nm bytes at msg[off..] padded to whole blocks.
  task automatic add_msg_blocks(input int off, input int nm, input bit blk0_first, input int llv);
    int   nblk;
    exp_t e;
    nblk = (nm == 0) ? 1 : (nm + BB - 1) / BB;
    for (int i = 0; i < nblk * BB; i++) begin
      e.d  = (i < nm) ? msg[off + i] : 8'h00;
      e.f  = blk0_first && (i < BB);
      e.l  = (nm == 0) || (i >= nm - 1);
      e.ll = LL_W'(llv);
      exp_q.push_back(e);
    end
  endtask

  task automatic push_expected(input int klen);
    int   n;
    int   nm;
    exp_t e;
    n  = msg.size();
    nm = n - klen;
    if (klen > 0) begin
      for (int i = 0; i < BB; i++) begin
        e.d  = (i < klen) ? msg[i] : 8'h00;
        e.f  = 1'b1;
        e.l  = (nm == 0) && (i >= klen - 1);
        e.ll = LL_W'(BB + nm);
        exp_q.push_back(e);
      end
      if (nm > 0) add_msg_blocks(klen, nm, 1'b0, BB + nm);
    end else begin
      add_msg_blocks(0, n, 1'b1, n);
    end
  endtask

  task automatic drive_beat(input logic [7:0] d, input logic last, input logic empty, input bit gaps);
    bit acc;
    int waitc;
    acc   = 1'b0;
    waitc = 0;
    while (!acc) begin
      @(negedge clk);
      if (gaps && ($urandom_range(0, 3) == 0)) begin
        in_valid_i = 1'b0;
      end else begin
        in_valid_i = 1'b1;
        in_data_i  = d;
        in_last_i  = last;
        in_empty_i = empty;
      end
      #1;
      acc = in_valid_i & in_ready_o;
      waitc++;
      if (!acc && waitc > 2000) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout: got no accept in %0d cycles, want accept", waitc);
        return;
      end
    end
    @(posedge clk);
  endtask

  task automatic send(input int klen, input bit gaps);
    int n;
    n = msg.size();
    push_expected(klen);
    key_len_i = 8'(klen);
    if (n == 0) begin
      drive_beat(8'h00, 1'b1, 1'b1, gaps);
    end else begin
      for (int i = 0; i < n; i++) drive_beat(msg[i], (i == n - 1), 1'b0, gaps);
    end
    @(negedge clk);
    in_valid_i = 1'b0;
    in_last_i  = 1'b0;
    in_empty_i = 1'b0;
  endtask

  task automatic wait_drain();
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < 5000) begin
      @(negedge clk);
      c++;
    end
    chk("drain_remaining", exp_q.size(), 0);
    @(negedge clk);
    chk("idle_busy", busy_o, 1'b0);
  endtask

  // Monitor: every presented byte must match the head of the scoreboard
  always @(negedge clk) begin
    if (!reset && data_v_o) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_byte: got data 0x%0h, want no byte", data_o);
      end else begin
        mon_e = exp_q.pop_front();
        chk("data", data_o, mon_e.d);
        chk("block_first", block_first_o, mon_e.f);
        chk("block_last", block_last_o, mon_e.l);
        if (mon_e.l) chk("ll", ll_o, mon_e.ll);
      end
      obs_cnt++;
    end
  end

  // Core-ready driver: random back-pressure or a directed 10-cycle stall
  initial begin
    core_ready_i = 1'b1;
    forever begin
      @(negedge clk);
      if (stall_at >= 0 && obs_cnt >= stall_at) begin
        stall_at     = -1;
        stall_start  = obs_cnt;
        core_ready_i = 1'b0;
        repeat (10) @(negedge clk);
        chk("stall_inflight_le1", ((obs_cnt - stall_start) <= 1), 1'b1);
        chk("stall_quiet", data_v_o, 1'b0);
        stall_done   = 1'b1;
        core_ready_i = 1'b1;
      end else begin
        core_ready_i = cr_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
    end
  end

  initial begin
    int c;
    int n;
    int klen;
    reset      = 1'b1;
    in_valid_i = 1'b0;
    in_data_i  = 8'h00;
    in_last_i  = 1'b0;
    in_empty_i = 1'b0;
    key_len_i  = 8'd0;
    repeat (3) @(negedge clk);
    chk("rst_data_v", data_v_o, 1'b0);
    chk("rst_first", block_first_o, 1'b0);
    chk("rst_last", block_last_o, 1'b0);
    chk("rst_ll", ll_o, 64'd0);
    chk("rst_busy", busy_o, 1'b0);
    reset = 1'b0;

    // "abc" with core stalled for 10 cycles at pad byte 50
    msg = '{8'h61, 8'h62, 8'h63};
    obs_cnt    = 0;
    stall_done = 1'b0;
    stall_at   = 53;
    send(0, 1'b0);
    wait_drain();
    chk("stall_happened", stall_done, 1'b1);

    // Exactly one block: no padding, idle right after the last accept
    msg.delete();
    for (int i = 0; i < 128; i++) msg.push_back(8'(i));
    send(0, 1'b0);
    chk("idle_after_full_block", busy_o, 1'b0);
    wait_drain();

    // 129 bytes: second block carries one byte
    msg.delete();
    for (int i = 0; i < 129; i++) msg.push_back(8'($urandom_range(0, 255)));
    send(0, 1'b0);
    wait_drain();

    // Zero-length message
    msg.delete();
    send(0, 1'b0);
    wait_drain();

    // Reset in the middle of padding
    msg = '{8'h61, 8'h62, 8'h63};
    obs_cnt = 0;
    send(0, 1'b0);
    c = 0;
    while (obs_cnt < 20 && c < 1000) begin
      @(negedge clk);
      c++;
    end
    chk("reached_pad", (obs_cnt >= 20), 1'b1);
    #2 reset = 1'b1;
    #1;
    chk("midrst_data_v", data_v_o, 1'b0);
    chk("midrst_first", block_first_o, 1'b0);
    chk("midrst_last", block_last_o, 1'b0);
    chk("midrst_ll", ll_o, 64'd0);
    chk("midrst_busy", busy_o, 1'b0);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    msg = '{8'h78, 8'h79, 8'h7a};
    send(0, 1'b0);
    wait_drain();

`ifdef BLAKE2_PAD_KEY_EN
    // Two-byte key followed by "ab"
    msg = '{8'hA5, 8'h5A, 8'h61, 8'h62};
    send(2, 1'b0);
    wait_drain();
    // Key only: key block is also the last block
    msg = '{8'h11, 8'h22, 8'h33};
    send(3, 1'b0);
    wait_drain();
`endif

    // Randomized lengths, data, valid gaps and core back-pressure
    cr_rand = 1'b1;
    for (int t = 0; t < 10; t++) begin
      n = $urandom_range(0, 300);
      msg.delete();
      for (int i = 0; i < n; i++) msg.push_back(8'($urandom_range(0, 255)));
      klen = 0;
`ifdef BLAKE2_PAD_KEY_EN
      if (n > 0 && $urandom_range(0, 1) == 1) klen = $urandom_range(1, (n < 64) ? n : 64);
`endif
      send(klen, 1'b1);
      wait_drain();
    end
    cr_rand = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
